loop_filter: RTL

//  Digital PI loop filter stage directly downstream of the phase/frequency detector.
//  - Consumes each completed measurement: diff_1 = reference-lead count, diff_2 = feedback-lead count.
//  - Produces a saturated control word for the DCO, plus lock and status flags.
//  - One clock; reset is synchronous and active-low.

---
 rtl/dpll_pkg.sv | 22 ++
 rtl/loop_filter_lock_detect.sv | 43 ++++
 rtl/loop_filter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/dpll_pkg.sv
// Shared types and helpers for the DPLL loop filter.
package dpll_pkg;

  localparam int unsigned N_BIT = 8;

  typedef enum logic [1:0] {IDLE, ERR, INT, OUT} fsm_t;

  typedef logic signed [N_BIT:0] err_t;

  // Clamp a signed value into the range of a two's-complement word of the given width.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                     input int unsigned       width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi) return hi;
    else if (value < lo) return lo;
    else return value;
  endfunction

endpackage

// File: rtl/loop_filter_lock_detect.sv
// Lock detector: counts consecutive small-error samples and publishes the locked flag.
module lock_detect #(
  parameter int unsigned ERR_W    = 9,
  parameter int unsigned LOCK_TOL = 2,
  parameter int unsigned LOCK_CNT = 8
) (
  input  logic                    Clock,
  input  logic                    nReset,
  input  logic signed [ERR_W-1:0] err,
  input  logic                    step,
  input  logic                    publish,
  input  logic                    clear,
  output logic                    locked
);

  localparam int unsigned CNT_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_CNT);

  logic [CNT_W-1:0] cnt;
  logic [ERR_W-1:0] err_mag;
  logic             in_tol;

  // Magnitude as unsigned so the most negative error still reads correctly.
  assign err_mag = err[ERR_W-1] ? ERR_W'(-err) : ERR_W'(err);
  assign in_tol  = (err_mag <= ERR_W'(LOCK_TOL));

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      cnt    <= '0;
      locked <= 1'b0;
    end else if (clear) begin
      cnt    <= '0;
      locked <= 1'b0;
    end else begin
      if (step) begin
        if (!in_tol) cnt <= '0;
        else if (cnt != CNT_MAX) cnt <= CNT_W'(cnt + 1'b1);
      end
      if (publish) locked <= (cnt == CNT_MAX);
    end
  end

endmodule

// File: rtl/loop_filter.sv
// PI loop filter between the phase/frequency detector and the DCO.
module loop_filter #(
  parameter int unsigned N_BIT       = dpll_pkg::N_BIT,
  parameter int unsigned C_BIT       = 16,
  parameter int unsigned INT_W       = 24,
  parameter int unsigned CTRL_CENTER = 32768,
  parameter int unsigned KP_SHL      = 4,
  parameter int unsigned KI_SHR      = 4,
  parameter int unsigned LOCK_TOL    = 2,
  parameter int unsigned LOCK_CNT    = 8
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             ready,
  input  logic             timeout,
  input  logic [N_BIT-1:0] diff_1,
  input  logic [N_BIT-1:0] diff_2,
  input  logic             clr_int,
  input  logic             freeze,
  output logic [C_BIT-1:0] ctrl_word,
  output logic             ctrl_valid,
  output logic             locked,
  output logic             overrun,
  output logic             int_sat
);

  import dpll_pkg::*;

  localparam int unsigned ERR_W  = N_BIT + 1;
  localparam int unsigned BASE_W = (INT_W > C_BIT) ? INT_W : C_BIT;
  localparam int unsigned P_W    = ERR_W + KP_SHL;
  // Wide enough to hold the center plus both terms without any wrap.
  localparam int unsigned SUM_W  = ((BASE_W > P_W) ? BASE_W : P_W) + 2;

  localparam logic signed [INT_W-1:0] INT_MAX = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic signed [INT_W-1:0] INT_MIN = {1'b1, {(INT_W-1){1'b0}}};
  localparam logic signed [SUM_W-1:0] CTRL_HI = SUM_W'((64'd1 << C_BIT) - 64'd1);
  localparam logic signed [SUM_W-1:0] CENTER  = SUM_W'(CTRL_CENTER);

  fsm_t                    state;
  fsm_t                    state_nxt;
  logic                    ready_q;
  logic                    timeout_q;
  logic                    rdy_edge;
  logic                    to_edge;
  logic                    accept;
  logic signed [ERR_W-1:0] err;
  logic signed [INT_W-1:0] integ;
  logic signed [INT_W-1:0] integ_nxt;
  logic signed [SUM_W-1:0] sum;
  logic [C_BIT-1:0]        ctrl_nxt;

  assign rdy_edge = ready & ~ready_q;
  assign to_edge  = timeout & ~timeout_q;
  assign accept   = (state == IDLE) && rdy_edge && !to_edge;

  always_ff @(posedge Clock) begin
    if (!nReset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ERR;
      ERR:     state_nxt = INT;
      INT:     state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Integrator next value: clear beats freeze beats the update.
  always_comb begin
    integ_nxt = integ;
    if (clr_int) integ_nxt = '0;
    else if ((state == INT) && !freeze)
      integ_nxt = INT_W'(sat_signed(64'(integ) + 64'(err), INT_W));
  end

  // Control word is formed from the fresh integrator so it lands together with ctrl_valid.
  always_comb begin
    sum = CENTER + (SUM_W'(err) <<< KP_SHL) + (SUM_W'(integ_nxt) >>> KI_SHR);
    if (sum[SUM_W-1])      ctrl_nxt = '0;
    else if (sum > CTRL_HI) ctrl_nxt = '1;
    else                   ctrl_nxt = C_BIT'(sum);
  end

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      ready_q    <= 1'b0;
      timeout_q  <= 1'b0;
      err        <= '0;
      integ      <= '0;
      ctrl_word  <= C_BIT'(CTRL_CENTER);
      ctrl_valid <= 1'b0;
      overrun    <= 1'b0;
      int_sat    <= 1'b0;
    end else begin
      ready_q    <= ready;
      timeout_q  <= timeout;
      ctrl_valid <= (state == INT);
      integ      <= integ_nxt;
      if (accept) err <= $signed({1'b0, diff_1}) - $signed({1'b0, diff_2});
      if (clr_int || (state == INT))
        int_sat <= (integ_nxt == INT_MAX) || (integ_nxt == INT_MIN);
      if (state == INT) ctrl_word <= ctrl_nxt;
      if (clr_int) overrun <= 1'b0;
      else if (rdy_edge && (state != IDLE)) overrun <= 1'b1;
    end
  end

  lock_detect #(
    .ERR_W   (ERR_W),
    .LOCK_TOL(LOCK_TOL),
    .LOCK_CNT(LOCK_CNT)
  ) u_lock (
    .Clock  (Clock),
    .nReset (nReset),
    .err    (err),
    .step   (state == ERR),
    .publish(state == INT),
    .clear  (to_edge),
    .locked (locked)
  );

endmodule
